// File: rtl/bus_reg_bank.sv
`default_nettype none
// ============================================================================
// Module   : bus_reg_bank
// Purpose  : General-purpose register file R0..R(NREGS-1). It is the
//            destination end of the shared datapath bus.
//            - Captures BusMuxOut into registers chosen by the direct
//              per-register strobes (R_in), by the encoded Gra/Grb/Grc
//              selection of IR fields with Rin, or by both.
//            - Exposes every register as a bus source through reg_q.
//            - Provides the encoded-register read port (rf_out) and the
//              sign-extended C operand (C_sign_extended).
//            - Keeps a sticky flag for conflicting control strobes.
//
// Ports    : clock            in   rising-edge clock
//            clear            in   asynchronous active-low reset
//            BusMuxOut        in   bus value to capture
//            IR               in   instruction register
//                                  (Ra=[26:23], Rb=[22:19], Rc=[18:15])
//            Gra/Grb/Grc      in   select Ra/Rb/Rc (priority Gra>Grb>Grc)
//            Rin              in   write the encoded register
//            Rout             in   drive the encoded register on rf_out
//            BAout            in   as Rout, but R0 reads as zero
//            R_in             in   direct per-register write strobes
//            reg_q            out  all registers, Ri at [i*WIDTH +: WIDTH]
//            rf_out           out  encoded-register read data
//            C_sign_extended  out  IR[18:0] sign-extended to WIDTH
//            sel_err          out  sticky control-conflict flag
//            last_wr_idx      out  last index written by the encoded path
//
// Config   : R0_HARDZERO_EN - when defined, R0 is a constant zero. Writes
//            to R0 are dropped, and reads of R0 return zero.
//
// Revision : 1.0 - initial release
// ============================================================================
module bus_reg_bank #(
  parameter int WIDTH = 32,
  parameter int NREGS = 16
) (
  input  logic                   clock,
  input  logic                   clear,
  input  logic [WIDTH-1:0]       BusMuxOut,
  input  logic [31:0]            IR,
  input  logic                   Gra,
  input  logic                   Grb,
  input  logic                   Grc,
  input  logic                   Rin,
  input  logic                   Rout,
  input  logic                   BAout,
  input  logic [NREGS-1:0]       R_in,
  output logic [NREGS*WIDTH-1:0] reg_q,
  output logic [WIDTH-1:0]       rf_out,
  output logic [WIDTH-1:0]       C_sign_extended,
  output logic                   sel_err,
  output logic [3:0]             last_wr_idx
);

  localparam int IDX_W  = 4;
  localparam int CIMM_W = 19;

  // --------------------------------------------------------------------------
  // State and next-state
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic             sel_err_q;
  logic             sel_err_d;
  logic [IDX_W-1:0] last_wr_idx_q;
  logic [IDX_W-1:0] last_wr_idx_d;

  // --------------------------------------------------------------------------
  // Select-and-encode of the IR register fields
  // --------------------------------------------------------------------------
  logic [IDX_W-1:0] w_ra;
  logic [IDX_W-1:0] w_rb;
  logic [IDX_W-1:0] w_rc;
  logic [IDX_W-1:0] w_idx;
  logic             w_sel_any;
  logic             w_enc_wr;
  logic             w_multi_sel;
  logic             w_conflict;
  logic             w_zero_read;
  logic [NREGS-1:0] w_wr_en;
  logic [4:0]       w_unused_ir;

  assign w_ra = IR[26:23];
  assign w_rb = IR[22:19];
  assign w_rc = IR[18:15];

  // The opcode bits play no part in register selection.
  assign w_unused_ir = IR[31:27];

  // When no select is asserted, the index is a don't-care. Every consumer
  // below is qualified by w_sel_any.
  always_comb begin
    w_idx = '0;
    if (Gra) begin
      w_idx = w_ra;
    end else if (Grb) begin
      w_idx = w_rb;
    end else if (Grc) begin
      w_idx = w_rc;
    end
  end

  assign w_sel_any = Gra | Grb | Grc;
  assign w_enc_wr  = Rin & w_sel_any;

  // Conflicts are flagged but not blocked. The cycle still executes, and the
  // priority encoder above resolves it.
  assign w_multi_sel = (Gra & Grb) | (Gra & Grc) | (Grb & Grc);
  assign w_conflict  = ((Rin | Rout | BAout) & w_multi_sel) | (Rout & BAout);

  // --------------------------------------------------------------------------
  // Write path: direct strobes OR'd with the decoded encoded strobe.
  // A direct and an encoded write may target the same register. Both carry
  // BusMuxOut, so no arbitration is needed.
  // --------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      w_wr_en[i] = R_in[i] | (w_enc_wr & (w_idx == IDX_W'(i)));
      regs_d[i]  = w_wr_en[i] ? BusMuxOut : regs_q[i];
    end
`ifdef R0_HARDZERO_EN
    // R0 is pinned at its reset value. Its flop is constant and is removed
    // in synthesis.
    w_wr_en[0] = 1'b0;
    regs_d[0]  = '0;
`endif
  end

  assign sel_err_d     = sel_err_q | w_conflict;
  assign last_wr_idx_d = w_enc_wr ? w_idx : last_wr_idx_q;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      sel_err_q     <= 1'b0;
      last_wr_idx_q <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      sel_err_q     <= sel_err_d;
      last_wr_idx_q <= last_wr_idx_d;
    end
  end

  // --------------------------------------------------------------------------
  // Read path. It shows the pre-edge register value and has no write-through
  // bypass. BAout gives base-address semantics, where R0 means "no base".
  // --------------------------------------------------------------------------
`ifdef R0_HARDZERO_EN
  assign w_zero_read = (w_idx == '0);
`else
  assign w_zero_read = BAout & (w_idx == '0);
`endif

  always_comb begin
    rf_out = '0;
    if ((Rout | BAout) & w_sel_any) begin
      if (w_zero_read) begin
        rf_out = '0;
      end else begin
        rf_out = regs_q[w_idx];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Bus-source view of every register
  // --------------------------------------------------------------------------
  for (genvar g = 0; g < NREGS; g++) begin : g_pack
    assign reg_q[g*WIDTH +: WIDTH] = regs_q[g];
  end

  // C operand: the 19-bit immediate of the instruction, sign-extended.
  assign C_sign_extended = {{(WIDTH-CIMM_W){IR[CIMM_W-1]}}, IR[CIMM_W-1:0]};

  assign sel_err     = sel_err_q;
  assign last_wr_idx = last_wr_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_reg_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_reg_bank
// Purpose  : Self-checking bench for bus_reg_bank.
//            - An array-based reference model is compared against the DUT
//              on every falling clock edge.
//            - Directed scenarios carry hand-computed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_reg_bank;

`ifdef R0_HARDZERO_EN
  localparam bit HZ = 1'b1;
`else
  localparam bit HZ = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          clear = 1'b0;
  logic [31:0]   BusMuxOut = '0;
  logic [31:0]   IR = '0;
  logic          Gra = 1'b0;
  logic          Grb = 1'b0;
  logic          Grc = 1'b0;
  logic          Rin = 1'b0;
  logic          Rout = 1'b0;
  logic          BAout = 1'b0;
  logic [15:0]   R_in = '0;
  logic [511:0]  reg_q;
  logic [31:0]   rf_out;
  logic [31:0]   C_sign_extended;
  logic          sel_err;
  logic [3:0]    last_wr_idx;

  int checks   = 0;
  int failures = 0;
  bit check_en = 1'b0;

  // Reference model state
  logic [31:0] m_regs [16];
  logic        m_err;
  logic [3:0]  m_last;

  bus_reg_bank #(.WIDTH(32), .NREGS(16)) dut (
    .clock           (clock),
    .clear           (clear),
    .BusMuxOut       (BusMuxOut),
    .IR              (IR),
    .Gra             (Gra),
    .Grb             (Grb),
    .Grc             (Grc),
    .Rin             (Rin),
    .Rout            (Rout),
    .BAout           (BAout),
    .R_in            (R_in),
    .reg_q           (reg_q),
    .rf_out          (rf_out),
    .C_sign_extended (C_sign_extended),
    .sel_err         (sel_err),
    .last_wr_idx     (last_wr_idx)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Register targeted by the IR fields, or -1 when nothing is selected.
  function automatic int target(input logic [31:0] ir, input logic a, input logic b, input logic c);
    if (a) return int'(ir[26:23]);
    if (b) return int'(ir[22:19]);
    if (c) return int'(ir[18:15]);
    return -1;
  endfunction

  function automatic int nsel(input logic a, input logic b, input logic c);
    return int'(a) + int'(b) + int'(c);
  endfunction

  function automatic logic [31:0] exp_rf();
    int t = target(IR, Gra, Grb, Grc);
    if (!(Rout || BAout) || t < 0) return 32'h0;
    if (t == 0 && (BAout || HZ)) return 32'h0;
    return m_regs[t];
  endfunction

  // Model update: clock-edge semantics of the register file
  always @(posedge clock or negedge clear) begin
    if (!clear) begin
      for (int i = 0; i < 16; i++) m_regs[i] <= 32'h0;
      m_err  <= 1'b0;
      m_last <= 4'h0;
    end else begin
      if (((Rin || Rout || BAout) && nsel(Gra, Grb, Grc) > 1) || (Rout && BAout))
        m_err <= 1'b1;
      for (int i = 0; i < 16; i++) begin
        if ((R_in[i] || (Rin && target(IR, Gra, Grb, Grc) == i)) && !(HZ && i == 0))
          m_regs[i] <= BusMuxOut;
      end
      if (Rin && target(IR, Gra, Grb, Grc) >= 0)
        m_last <= 4'(target(IR, Gra, Grb, Grc));
    end
  end

  // Compare process: outputs against the model, away from the active edge
  always @(negedge clock) begin
    if (check_en) begin
      for (int i = 0; i < 16; i++) chk($sformatf("model_reg%0d", i), reg_q[i*32 +: 32], m_regs[i]);
      chk("model_rf_out", rf_out, exp_rf());
      chk("model_csext", C_sign_extended, {{13{IR[18]}}, IR[18:0]});
      chk("model_sel_err", {31'h0, sel_err}, {31'h0, m_err});
      chk("model_last_wr_idx", {28'h0, last_wr_idx}, {28'h0, m_last});
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    // Reset state
    repeat (2) tick();
    chk("reset_regq_any", {31'h0, |reg_q}, 32'h0);
    chk("reset_sel_err", {31'h0, sel_err}, 32'h0);
    chk("reset_rf_out", rf_out, 32'h0);
    chk("reset_last_idx", {28'h0, last_wr_idx}, 32'h0);
    clear = 1'b1;
    check_en = 1'b1;

    // Direct multi-register write
    BusMuxOut = 32'h12345678;
    R_in = 16'h0024;
    tick();
    R_in = 16'h0;
    #1;
    chk("direct_R2", reg_q[2*32 +: 32], 32'h12345678);
    chk("direct_R5", reg_q[5*32 +: 32], 32'h12345678);
    chk("direct_R4_untouched", reg_q[4*32 +: 32], 32'h0);

    // Encoded write through Ra, then read back
    IR = 32'(3) << 23; Gra = 1'b1; Rin = 1'b1; BusMuxOut = 32'hDEADBEEF;
    tick();
    Rin = 1'b0; Rout = 1'b1;
    #1;
    chk("enc_rf_out", rf_out, 32'hDEADBEEF);
    chk("enc_last_idx", {28'h0, last_wr_idx}, 32'h3);
    tick();
    Rout = 1'b0; Gra = 1'b0;

    // R0 read via Rout and via BAout
    R_in = 16'h0001; BusMuxOut = 32'h40;
    tick();
    R_in = 16'h0; IR = 32'h0; Gra = 1'b1; Rout = 1'b1;
    #1;
    chk("r0_rout", rf_out, HZ ? 32'h0 : 32'h40);
    Rout = 1'b0; BAout = 1'b1;
    #1;
    chk("r0_baout", rf_out, 32'h0);
    tick();
    BAout = 1'b0; Gra = 1'b0;

    // Same-cycle read and write of R2, plus an overlapping direct strobe
    IR = 32'(2) << 23; Gra = 1'b1; Rin = 1'b1; Rout = 1'b1; R_in = 16'h0004;
    BusMuxOut = 32'hA5A5A5A5;
    #1;
    chk("rw_old_value", rf_out, 32'h12345678);
    tick();
    Rin = 1'b0; R_in = 16'h0;
    #1;
    chk("rw_new_value", rf_out, 32'hA5A5A5A5);
    chk("rw_no_err", {31'h0, sel_err}, 32'h0);
    Rout = 1'b0; Gra = 1'b0;

    // Rin without any select writes nothing and holds last_wr_idx
    Rin = 1'b1; BusMuxOut = 32'hFFFFFFFF;
    tick();
    Rin = 1'b0;
    #1;
    chk("nosel_last_idx", {28'h0, last_wr_idx}, 32'h2);
    chk("nosel_R3_kept", reg_q[3*32 +: 32], 32'hDEADBEEF);

    // Encoded writes through Rc to every register, then one write through Rb
    for (int k = 1; k < 16; k++) begin
      IR = 32'(k) << 15; Grc = 1'b1; Rin = 1'b1;
      BusMuxOut = 32'(k) * 32'h01010101;
      tick();
    end
    Grc = 1'b0;
    IR = (32'(9) << 19) | (32'(4) << 15); Grb = 1'b1; BusMuxOut = 32'hCAFEF00D;
    tick();
    Rin = 1'b0; Grb = 1'b0;
    #1;
    chk("grb_R9", reg_q[9*32 +: 32], 32'hCAFEF00D);
    chk("grc_R4", reg_q[4*32 +: 32], 32'h04040404);
    chk("grb_last_idx", {28'h0, last_wr_idx}, 32'h9);

    // Multiple selects with Rout: flagged, and priority picks Ra
    IR = (32'(5) << 23) | (32'(2) << 19); Gra = 1'b1; Grb = 1'b1; Rout = 1'b1;
    #1;
    chk("conflict_rf_out", rf_out, 32'h05050505);
    tick();
    Gra = 1'b0; Grb = 1'b0; Rout = 1'b0;
    #1;
    chk("conflict_sel_err", {31'h0, sel_err}, 32'h1);
    repeat (3) tick();
    chk("conflict_sticky", {31'h0, sel_err}, 32'h1);

    // Reset asserted before an edge with pending writes: nothing is written
    R_in = 16'hFFFF; BusMuxOut = 32'h77777777;
    @(negedge clock);
    clear = 1'b0;
    tick();
    chk("midrst_regq_any", {31'h0, |reg_q}, 32'h0);
    chk("midrst_sel_err", {31'h0, sel_err}, 32'h0);
    R_in = 16'h0;
    clear = 1'b1;

    // Rout and BAout together form a conflict on their own
    IR = 32'(7) << 23; Gra = 1'b1; Rout = 1'b1; BAout = 1'b1;
    tick();
    Gra = 1'b0; Rout = 1'b0; BAout = 1'b0;
    #1;
    chk("rout_baout_err", {31'h0, sel_err}, 32'h1);

    // C operand sign extension
    IR = 32'h00040000;
    #1;
    chk("csext_neg", C_sign_extended, 32'hFFFC0000);
    IR = 32'h00000123;
    #1;
    chk("csext_pos", C_sign_extended, 32'h00000123);

    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
